// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input/output sequencers.
// Holds the loader FSM encoding, the sample FIFO geometry and the address bit-reversal.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH   = 4;
  localparam int FIFO_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BITREV_MAX_W = 16;

  // Reverses the low `width` bits of v; bits above `width` come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                      input int width);
    logic [BITREV_MAX_W-1:0] src;
    logic [BITREV_MAX_W-1:0] res;
    src = v;
    res = {BITREV_MAX_W{1'b0}};
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) begin
        res = {res[BITREV_MAX_W-2:0], src[0]};
        src = src >> 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Four-entry show-ahead FIFO of (sample, slot index) pairs between the ROM
// read pipeline and the FFT input handshake; exposes its fill count.
module sample_fifo
  import fft_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_r [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_r;
  logic [FIFO_PTR_W-1:0] rd_ptr_r;
  logic [FIFO_CNT_W-1:0] count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign push_ok_s = push && (count_r != FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_ok_s  = pop && (count_r != {FIFO_CNT_W{1'b0}});

  // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {FIFO_PTR_W{1'b0}};
      rd_ptr_r <= {FIFO_PTR_W{1'b0}};
      count_r  <= {FIFO_CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + FIFO_PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
        2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {FIFO_CNT_W{1'b0}});

endmodule

// File: rtl/rom_in_loader.sv
// Streams one FFT input frame out of ROM_IN, optionally in bit-reversed address
// order, absorbing the one-cycle ROM latency and downstream backpressure.
module rom_in_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = 9,
  parameter int ADDR_WIDTH  = 9,
  parameter int BIT_REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] data_index,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int OCC_W   = FIFO_CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_K = {ADDR_WIDTH{1'b1}};

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   k_r;
  logic [ADDR_WIDTH-1:0]   rom_addr_r;
  logic [ADDR_WIDTH-1:0]   a_idx_r;
  logic [ADDR_WIDTH-1:0]   q_idx_r;
  logic                    a_v_r;
  logic                    q_v_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    issue_s;
  logic                    done_set_s;
  logic                    room_s;
  logic                    xfer_s;
  logic                    last_xfer_s;
  logic [ADDR_WIDTH-1:0]   issue_addr_s;
  logic [OCC_W-1:0]        occupancy_s;
  logic [ENTRY_W-1:0]      head_s;
  logic [FIFO_CNT_W-1:0]   fifo_count_s;
  logic                    fifo_empty_s;

  // In-flight reads are counted against the FIFO so that every push is guaranteed a slot.
  assign occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(a_v_r) + OCC_W'(q_v_r);
  assign room_s      = (occupancy_s < OCC_W'(FIFO_DEPTH));
  assign xfer_s      = !fifo_empty_s && data_ready;
  assign last_xfer_s = xfer_s && (head_s[ADDR_WIDTH-1:0] == LAST_K);

  // ROM address for the current issue slot.
  always_comb begin
    issue_addr_s = k_r;
    if (BIT_REVERSE != 0) begin
      issue_addr_s = ADDR_WIDTH'(bitrev(BITREV_MAX_W'(k_r), ADDR_WIDTH));
    end else begin
      issue_addr_s = k_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? RUN : IDLE;
      RUN:     state_nxt_s = (issue_s && (k_r == LAST_K)) ? DRAIN : RUN;
      DRAIN:   state_nxt_s = last_xfer_s ? IDLE : DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: when to issue a ROM read and when the frame completes.
  always_comb begin
    issue_s    = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      IDLE:    issue_s    = start;
      RUN:     issue_s    = room_s;
      DRAIN:   done_set_s = last_xfer_s;
      default: begin
        issue_s    = 1'b0;
        done_set_s = 1'b0;
      end
    endcase
  end

  // Issue counter and the two-stage read pipeline; the address holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r        <= {ADDR_WIDTH{1'b0}};
      rom_addr_r <= {ADDR_WIDTH{1'b0}};
      a_idx_r    <= {ADDR_WIDTH{1'b0}};
      a_v_r      <= 1'b0;
      q_idx_r    <= {ADDR_WIDTH{1'b0}};
      q_v_r      <= 1'b0;
    end else begin
      if (issue_s) begin
        k_r        <= k_r + ADDR_WIDTH'(1);
        rom_addr_r <= issue_addr_s;
        a_idx_r    <= k_r;
        a_v_r      <= 1'b1;
      end else begin
        a_v_r <= 1'b0;
      end
      q_v_r   <= a_v_r;
      q_idx_r <= a_idx_r;
    end
  end

  // Frame status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= done_set_s;
    end
  end

  sample_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_v_r),
    .push_data({rom_q, q_idx_r}),
    .pop      (xfer_s),
    .head     (head_s),
    .count    (fifo_count_s),
    .empty    (fifo_empty_s)
  );

  assign rom_addr   = rom_addr_r;
  assign data_out   = head_s[ENTRY_W-1:ADDR_WIDTH];
  assign data_index = head_s[ADDR_WIDTH-1:0];
  assign data_valid = !fifo_empty_s;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_rom_in_loader.sv
// Directed bench for rom_in_loader: 8-point bit-reversed and natural-order frames,
// backpressure, back-to-back frames, mid-frame reset and a full 512-point frame.
module tb_rom_in_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total;
  int   bad;

  logic       a_start, a_valid, a_ready, a_busy, a_done;
  logic [2:0] a_rom_addr, a_data_index;
  logic [8:0] a_rom_q, a_data_out;

  logic       b_start, b_valid, b_ready, b_busy, b_done;
  logic [2:0] b_rom_addr, b_data_index;
  logic [8:0] b_rom_q, b_data_out;

  logic       c_start, c_valid, c_ready, c_busy, c_done;
  logic [8:0] c_rom_addr, c_data_index;
  logic [8:0] c_rom_q, c_data_out;

  rom_in_loader #(.DATA_WIDTH(9), .ADDR_WIDTH(3), .BIT_REVERSE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .rom_addr(a_rom_addr), .rom_q(a_rom_q),
    .data_out(a_data_out), .data_index(a_data_index), .data_valid(a_valid),
    .data_ready(a_ready), .busy(a_busy), .done(a_done));

  rom_in_loader #(.DATA_WIDTH(9), .ADDR_WIDTH(3), .BIT_REVERSE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .rom_addr(b_rom_addr), .rom_q(b_rom_q),
    .data_out(b_data_out), .data_index(b_data_index), .data_valid(b_valid),
    .data_ready(b_ready), .busy(b_busy), .done(b_done));

  rom_in_loader dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .rom_addr(c_rom_addr), .rom_q(c_rom_q),
    .data_out(c_data_out), .data_index(c_data_index), .data_valid(c_valid),
    .data_ready(c_ready), .busy(c_busy), .done(c_done));

  // ROM models: one-cycle synchronous read.
  always @(posedge clk) begin
    a_rom_q <= 9'(a_rom_addr) + 9'd10;
    b_rom_q <= 9'(b_rom_addr) + 9'd10;
    c_rom_q <= c_rom_addr;
  end

  int br_addr [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int br_data [8] = '{10, 14, 12, 16, 11, 15, 13, 17};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev9(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) r = r | (1 << (8 - i));
    end
    return r;
  endfunction

  initial begin
    int n, dones, max_cnt, extra, last_idx, last_data;
    bit done_seen;
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    repeat (2) tick();
    chk("rst_addr",  int'(a_rom_addr),   0);
    chk("rst_data",  int'(a_data_out),   0);
    chk("rst_index", int'(a_data_index), 0);
    chk("rst_valid", int'(a_valid),      0);
    chk("rst_busy",  int'(a_busy),       0);
    chk("rst_done",  int'(a_done),       0);
    rst_n = 1'b1;
    tick();

    // Bit-reversed frame, ready held high; j counts edges after the start edge.
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) chk("t1_addr", int'(a_rom_addr), br_addr[j]);
      chk("t1_valid", int'(a_valid), int'(j >= 2 && j <= 9));
      if (j >= 2 && j <= 9) begin
        chk("t1_data",  int'(a_data_out),   br_data[j-2]);
        chk("t1_index", int'(a_data_index), j - 2);
      end
      chk("t1_done", int'(a_done), int'(j == 10));
      chk("t1_busy", int'(a_busy), int'(j <= 9));
      tick();
    end

    // Natural-order frame.
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) chk("t2_addr", int'(b_rom_addr), j);
      chk("t2_valid", int'(b_valid), int'(j >= 2 && j <= 9));
      if (j >= 2 && j <= 9) begin
        chk("t2_data",  int'(b_data_out),   10 + j - 2);
        chk("t2_index", int'(b_data_index), j - 2);
      end
      chk("t2_done", int'(b_done), int'(j == 10));
      tick();
    end

    // Backpressure: ready low for 10 cycles, issue must stall at 4 buffered.
    a_ready = 1'b0; max_cnt = 0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (int'(dut_a.u_fifo.count) > max_cnt) max_cnt = int'(dut_a.u_fifo.count);
      if (j >= 3) chk("t3_hold_addr", int'(a_rom_addr), 6);
      tick();
    end
    chk("t3_full_cnt", int'(dut_a.u_fifo.count), 4);
    chk("t3_head_data", int'(a_data_out), 10);
    a_ready = 1'b1; n = 0; done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (int'(dut_a.u_fifo.count) > max_cnt) max_cnt = int'(dut_a.u_fifo.count);
      if (a_valid && a_ready) begin
        if (n < 8) begin
          chk("t3_index", int'(a_data_index), n);
          chk("t3_data",  int'(a_data_out),   br_data[n]);
        end else begin
          chk("t3_extra", n, 7);
        end
        n++;
      end
      if (a_done) done_seen = 1'b1;
      tick();
    end
    chk("t3_count", n, 8);
    chk("t3_done", int'(done_seen), 1);
    chk("t3_max_cnt", max_cnt, 4);

    // Three back-to-back frames with start held high and random ready.
    a_start = 1'b1; n = 0; dones = 0;
    for (int c = 0; c < 400 && dones < 3; c++) begin
      a_ready = 1'($urandom_range(0, 1));
      if (a_valid && a_ready) begin
        chk("t4_index", int'(a_data_index), n % 8);
        chk("t4_data",  int'(a_data_out),   br_data[n % 8]);
        n++;
      end
      if (a_done) begin
        dones++;
        if (dones == 3) a_start = 1'b0;
      end
      tick();
    end
    a_ready = 1'b1; extra = 0;
    for (int c = 0; c < 15; c++) begin
      if (a_valid || a_done) extra++;
      tick();
    end
    chk("t4_transfers", n, 24);
    chk("t4_dones", dones, 3);
    chk("t4_quiet", extra, 0);
    chk("t4_busy", int'(a_busy), 0);

    // Reset after 3 transfers, then a clean restart.
    a_ready = 1'b1; n = 0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (a_valid && a_ready) n++;
      tick();
    end
    chk("t5_pre_xfers", n, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_addr",  int'(a_rom_addr),   0);
    chk("t5_data",  int'(a_data_out),   0);
    chk("t5_index", int'(a_data_index), 0);
    chk("t5_valid", int'(a_valid),      0);
    chk("t5_busy",  int'(a_busy),       0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (a_done) extra++;
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (a_done) extra++;
      tick();
    end
    chk("t5_no_done", extra, 0);
    a_start = 1'b1; tick(); a_start = 1'b0;
    n = 0; done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (a_valid && a_ready) begin
        if (n < 8) begin
          chk("t5_index", int'(a_data_index), n);
          chk("t5_data",  int'(a_data_out),   br_data[n]);
        end else begin
          chk("t5_extra", n, 7);
        end
        n++;
      end
      if (a_done) done_seen = 1'b1;
      tick();
    end
    chk("t5_count", n, 8);
    chk("t5_done", int'(done_seen), 1);

    // Full 512-point frame with default parameters.
    c_start = 1'b1; tick(); c_start = 1'b0;
    n = 0; dones = 0; last_idx = -1; last_data = -1;
    for (int c = 0; c < 600 && dones == 0; c++) begin
      if (c_valid && c_ready) begin
        chk("t6_index", int'(c_data_index), n % 512);
        chk("t6_data",  int'(c_data_out),   rev9(n % 512));
        last_idx = int'(c_data_index);
        last_data = int'(c_data_out);
        n++;
      end
      if (c_done) dones++;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      if (c_done) dones++;
      tick();
    end
    chk("t6_count", n, 512);
    chk("t6_last_index", last_idx, 511);
    chk("t6_last_data", last_data, 511);
    chk("t6_dones", dones, 1);
    chk("t6_busy", int'(c_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_in_loader.md
# rom_in_loader

Sequencer that streams the FFT input frame out of `ROM_IN` into the butterfly datapath. On `start` it walks all 2^ADDR_WIDTH ROM addresses, in bit-reversed order when configured, so the DIT FFT receives its input in natural slot order. It absorbs the ROM's one-cycle synchronous read latency and accepts downstream backpressure through a small output FIFO. It sits between `ROM_IN` (address/data) and the FFT input stage (valid/ready).

## Interface
- `DATA_WIDTH`, 9: sample width; matches `ROM_IN`.
- `ADDR_WIDTH`, 9: ROM address width; frame length N = 2^ADDR_WIDTH.
- `BIT_REVERSE`, 1: 1 = ROM address is bitrev(k); 0 = ROM address is k.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `rom_addr`  out  ADDR_WIDTH  address to `ROM_IN.addr`.
- `rom_q`  in  DATA_WIDTH  `ROM_IN.q`; valid one cycle after the address.
- `data_out`  out  DATA_WIDTH  sample to the FFT.
- `data_index`  out  ADDR_WIDTH  natural slot k of `data_out`.
- `data_valid`  out  1  `data_out`/`data_index` valid.
- `data_ready`  in  1  consumer accepts; transfer = valid & ready.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- Reset values: `rom_addr`=0, `data_out`=0, `data_index`=0, `data_valid`=0, `busy`=0, `done`=0. The FIFO is emptied and all counters and flags are cleared.
- States:
  - IDLE: when `start`=1, go to RUN, issue index 0, set `busy`.
  - RUN: issue one index per cycle while the issue rule holds. After index N-1 is issued, go to DRAIN.
  - DRAIN: when the transfer with index N-1 occurs, go to IDLE, pulse `done`, clear `busy`.
- `start` is ignored outside IDLE.
- Issue counter k: 0..N-1, ADDR_WIDTH bits; no wrap within a frame. `rom_addr` = bitrev(k) or k, registered.
- Read pipeline: flag `a_v` marks a newly issued address; `q_v` <= `a_v`. When `q_v`=1, push {`rom_q`, k_delayed} into the FIFO. The FIFO holds (data, index) pairs.
- Issue rule: issue only when fifo_count + `a_v` + `q_v` < 4. This guarantees space for every push, so no push is ever dropped or stalled.
- Outputs are show-ahead from the FIFO head. `data_valid` = FIFO not empty. A transfer pops the head.
- When not issuing, `rom_addr` holds its value. `a_v`=0 guarantees the repeated ROM read is never pushed.
- Simultaneous push and pop in one cycle: count is unchanged. The FIFO is never pushed while full (by construction).
- `rst_n` low mid-frame: immediate return to reset values. The frame is abandoned; no `done`.

## Timing
- Start sampled at edge E0: `rom_addr`=addr(0) after E0. The ROM captures it at E1. The loader pushes at E2. `data_valid`=1 after E2, so latency is 2 cycles from the start edge.
- With `data_ready` held high: one transfer per cycle. The last transfer is at edge E0+N+1. `done` is high the cycle after that edge. `busy` is 1 from E0 through the last-transfer edge.
- With `data_ready` low: at most 4 samples are buffered. Issue stops and resumes the cycle after space is freed.
- Back-to-back frames: the earliest next `start` is sampled the cycle `done` is high.

## Structure
- Shared package `fft_pkg`:
  - state enum {IDLE, RUN, DRAIN}
  - constant FIFO_DEPTH=4
  - a `bitrev` function parameterised by ADDR_WIDTH
- One sub-module, `sample_fifo`: synchronous, depth 4, width DATA_WIDTH+ADDR_WIDTH, show-ahead, async active-low reset, exposes count.

## Test plan
- ADDR_WIDTH=3, BIT_REVERSE=1, ROM[a]=a+10, `data_ready`=1, pulse `start` → `rom_addr` sequence 0,4,2,6,1,5,3,7. Outputs (data, index) = (10,0),(14,1),(12,2),(16,3),(11,4),(15,5),(13,6),(17,7) on 8 consecutive cycles. First valid 2 cycles after the start edge; `done` one cycle after the last.
- Same setup with BIT_REVERSE=0 → data 10..17 in order, indices 0..7.
- `data_ready`=0 for 10 cycles after start → FIFO count reaches 4 and never 5, no issue while full. After release, all 8 samples arrive in correct order with no loss or duplicate.
- Random `data_ready` (50%) over 3 back-to-back frames, with `start` held high → exactly 24 transfers and 3 `done` pulses. `start` during `busy` has no effect.
- `rst_n` asserted after 3 transfers → all outputs at reset values immediately, no `done`. A new `start` after release restarts from index 0.
- Default parameters (N=512), ROM[a]=a[8:0] → 512 transfers. The 512th carries index 511, data 511. `done` pulses once.
